// File: rtl/fcpu_pkg.sv
// Shared AXI encodings and the AR request record used by the code-RAM read slave.
package fcpu_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AR_ID_W   = 4;
    localparam int AR_ADDR_W = 32;

    typedef struct packed {
        logic [AR_ID_W-1:0]   id;
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [1:0]           burst;
        logic                 err;   // request-wide SLVERR
    } ar_req_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/cram_burst_addr_gen.sv
// Combinational next-beat address and per-beat decode-error check for an AXI burst.
module cram_burst_addr_gen
    import fcpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CRAM_ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              decerr
);
    localparam int WA_W = ADDR_W - 2;

    logic [WA_W-1:0] waddr;
    logic [WA_W-1:0] wmask;
    logic [WA_W-1:0] wnext;

    assign waddr = addr[ADDR_W-1:2];
    assign wmask = WA_W'(len);

    always_comb begin
        case (burst)
            AXI_BURST_INCR: wnext = waddr + WA_W'(1);
            AXI_BURST_WRAP: wnext = (waddr & ~wmask) | ((waddr + WA_W'(1)) & wmask);
            default:        wnext = waddr;
        endcase
    end

    assign next_addr = {wnext, addr[1:0]};

    // Any byte address bit above the RAM window means the beat falls outside it.
    generate
        if (ADDR_W > CRAM_ADDR_W + 2) begin : g_dec
            assign decerr = |addr[ADDR_W-1:CRAM_ADDR_W+2];
        end else begin : g_nodec
            assign decerr = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cram_axi_rd_slave.sv
// AXI4 read-only slave for the code RAM with a side loader write port.
// Define CRAM_AR_SKID_EN for a 1-entry AR buffer that overlaps the next request with the current burst.
module cram_axi_rd_slave
    import fcpu_pkg::*;
#(
    parameter int ID_W        = AR_ID_W,
    parameter int ADDR_W      = AR_ADDR_W,
    parameter int DATA_W      = 32,
    parameter int CRAM_ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [ID_W-1:0]        s_cram_arid,
    input  logic [ADDR_W-1:0]      s_cram_araddr,
    input  logic [7:0]             s_cram_arlen,
    input  logic [2:0]             s_cram_arsize,
    input  logic [1:0]             s_cram_arburst,
    input  logic                   s_cram_arlock,
    input  logic [3:0]             s_cram_arcache,
    input  logic [2:0]             s_cram_arprot,
    input  logic [3:0]             s_cram_arqos,
    input  logic                   s_cram_arvalid,
    output logic                   s_cram_arready,
    output logic [ID_W-1:0]        s_cram_rid,
    output logic [DATA_W-1:0]      s_cram_rdata,
    output logic [1:0]             s_cram_rresp,
    output logic                   s_cram_rlast,
    output logic                   s_cram_rvalid,
    input  logic                   s_cram_rready,
    input  logic                   ld_we,
    input  logic [CRAM_ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0]      ld_data
);
    localparam int DEPTH = 2 ** CRAM_ADDR_W;

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e            state_q, state_d;
    ar_req_t           cur_q, cur_d;
    logic [8:0]        cnt_q, cnt_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;

    logic [DATA_W-1:0] mem [DEPTH];

    ar_req_t           ar_in, src;
    logic [8:0]        src_cnt;
    logic              rd_en, ar_hs, last_hs, decerr;
    logic [ADDR_W-1:0] nxt_addr;
    logic              unused_ar_attr;

`ifdef CRAM_AR_SKID_EN
    ar_req_t skid_q, skid_d;
    logic    skid_vld_q, skid_vld_d;
`endif

    assign unused_ar_attr = ^{s_cram_arlock, s_cram_arcache, s_cram_arprot, s_cram_arqos};

    assign ar_hs   = s_cram_arvalid && arready_q;
    assign last_hs = rvalid_q && s_cram_rready && rlast_q;

    always_comb begin
        ar_in.id    = s_cram_arid;
        ar_in.addr  = s_cram_araddr;
        ar_in.len   = s_cram_arlen;
        ar_in.burst = s_cram_arburst;
        ar_in.err   = (s_cram_arsize != 3'd2) || (s_cram_arburst == 2'b11) ||
                      ((s_cram_arburst == AXI_BURST_WRAP) && !wrap_len_ok(s_cram_arlen));
    end

    cram_burst_addr_gen #(
        .ADDR_W      (ADDR_W),
        .CRAM_ADDR_W (CRAM_ADDR_W)
    ) u_addr_gen (
        .addr      (src.addr),
        .len       (src.len),
        .burst     (src.burst),
        .next_addr (nxt_addr),
        .decerr    (decerr)
    );

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        src      = cur_q;
        src_cnt  = cnt_q;
        rd_en    = 1'b0;
`ifdef CRAM_AR_SKID_EN
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
`endif
        if (rvalid_q && s_cram_rready) rvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    cur_d   = ar_in;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end
            end
            default: begin
                if (last_hs) begin
`ifdef CRAM_AR_SKID_EN
                    // Issue beat 0 of the buffered burst now so R stays gap-free.
                    if (skid_vld_q) begin
                        src        = skid_q;
                        src_cnt    = '0;
                        rd_en      = 1'b1;
                        skid_vld_d = 1'b0;
                    end else
`endif
                    if (ar_hs) begin
                        cur_d = ar_in;
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
`ifdef CRAM_AR_SKID_EN
                    if (ar_hs) begin
                        skid_d     = ar_in;
                        skid_vld_d = 1'b1;
                    end
`endif
                    rd_en = (cnt_q <= {1'b0, cur_q.len}) && (!rvalid_q || s_cram_rready);
                end
            end
        endcase

        if (rd_en) begin
            cur_d      = src;
            cur_d.addr = nxt_addr;
            cnt_d      = src_cnt + 9'd1;
            rvalid_d   = 1'b1;
            rid_d      = src.id;
            rlast_d    = (src_cnt == {1'b0, src.len});
            if (src.err)     rresp_d = AXI_RESP_SLVERR;
            else if (decerr) rresp_d = AXI_RESP_DECERR;
            else             rresp_d = AXI_RESP_OKAY;
            rdata_d = (rresp_d == AXI_RESP_OKAY) ? mem[src.addr[CRAM_ADDR_W+1:2]] : '0;
        end

        arready_d = (state_d == ST_IDLE);
`ifdef CRAM_AR_SKID_EN
        arready_d = arready_d || !skid_vld_d;
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

`ifdef CRAM_AR_SKID_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`endif

    // Contents survive reset; the read path above sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end

    assign s_cram_arready = arready_q;
    assign s_cram_rvalid  = rvalid_q;
    assign s_cram_rid     = rid_q;
    assign s_cram_rdata   = rdata_q;
    assign s_cram_rresp   = rresp_q;
    assign s_cram_rlast   = rlast_q;

endmodule

// File: tb/tb_cram_axi_rd_slave.sv
// Randomized self-checking bench for cram_axi_rd_slave against an array/queue reference model.
module tb_cram_axi_rd_slave;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  s_cram_arid = '0;
    logic [31:0] s_cram_araddr = '0;
    logic [7:0]  s_cram_arlen = '0;
    logic [2:0]  s_cram_arsize = 3'd2;
    logic [1:0]  s_cram_arburst = 2'b01;
    logic        s_cram_arvalid = 1'b0;
    logic        s_cram_arready;
    logic [3:0]  s_cram_rid;
    logic [31:0] s_cram_rdata;
    logic [1:0]  s_cram_rresp;
    logic        s_cram_rlast;
    logic        s_cram_rvalid;
    logic        s_cram_rready = 1'b0;
    logic        ld_we = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    cram_axi_rd_slave dut (
        .clk            (clk),
        .nrst           (nrst),
        .s_cram_arid    (s_cram_arid),
        .s_cram_araddr  (s_cram_araddr),
        .s_cram_arlen   (s_cram_arlen),
        .s_cram_arsize  (s_cram_arsize),
        .s_cram_arburst (s_cram_arburst),
        .s_cram_arlock  (1'b0),
        .s_cram_arcache (4'd0),
        .s_cram_arprot  (3'd0),
        .s_cram_arqos   (4'd0),
        .s_cram_arvalid (s_cram_arvalid),
        .s_cram_arready (s_cram_arready),
        .s_cram_rid     (s_cram_rid),
        .s_cram_rdata   (s_cram_rdata),
        .s_cram_rresp   (s_cram_rresp),
        .s_cram_rlast   (s_cram_rlast),
        .s_cram_rvalid  (s_cram_rvalid),
        .s_cram_rready  (s_cram_rready),
        .ld_we          (ld_we),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic ld(input int a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = 12'(a);
        ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        mem_m[a] = d;
    endtask

    // Expected beats straight from the addressing/response rules, appended to exp_q.
    function automatic void build_exp(input logic [31:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
        beat_t  b;
        longint w, n, base;
        bit     slv;
        n   = longint'(len) + 1;
        slv = (size != 3'd2) || (burst == 2'd3) ||
              (burst == 2'd2 && !(n == 2 || n == 4 || n == 8 || n == 16));
        w   = longint'(addr) / 4;
        for (int k = 0; k < n; k++) begin
            if (slv) begin
                b.resp = 2'b10; b.data = '0;
            end else if (w * 4 >= DEPTH * 4) begin
                b.resp = 2'b11; b.data = '0;
            end else begin
                b.resp = 2'b00; b.data = mem_m[int'(w % DEPTH)];
            end
            b.last = (k == n - 1);
            exp_q.push_back(b);
            if (burst == 2'd1) w = (w + 1) % (longint'(1) << 30);
            else if (burst == 2'd2) begin
                base = w - (w % n);
                w    = base + ((w + 1) % n);
            end
        end
    endfunction

    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int rmode);
        beat_t       e;
        int          t, lat, cyc, beat;
        bit          stalled, rr;
        logic [31:0] sd;
        logic [1:0]  sr;
        logic        sl;
        exp_q.delete();
        build_exp(addr, len, size, burst);
        s_cram_arid = id; s_cram_araddr = addr; s_cram_arlen = len;
        s_cram_arsize = size; s_cram_arburst = burst; s_cram_arvalid = 1'b1;
        s_cram_rready = 1'b0;
        t = 0;
        while (!s_cram_arready && t < 20) begin @(negedge clk); t++; end
        chk("ar_accept", s_cram_arready, 1);
        @(negedge clk);
        s_cram_arvalid = 1'b0;
        lat = 0;
        while (!s_cram_rvalid && lat < 20) begin @(negedge clk); lat++; end
        chk("first_lat", lat, 1);
        beat = 0; cyc = 0; stalled = 0; sd = '0; sr = '0; sl = 1'b0;
        while (beat <= int'(len) && cyc < 1000) begin
            case (rmode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 3 == 0);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            s_cram_rready = rr;
            if (stalled) begin
                chk("rvalid_hold", s_cram_rvalid, 1);
                chk("rdata_hold", s_cram_rdata, sd);
                chk("rresp_hold", s_cram_rresp, sr);
                chk("rlast_hold", s_cram_rlast, sl);
            end
            stalled = 0;
            if (s_cram_rvalid) begin
                if (rr) begin
                    e = exp_q.pop_front();
                    chk("rid", s_cram_rid, id);
                    chk("rdata", s_cram_rdata, e.data);
                    chk("rresp", s_cram_rresp, e.resp);
                    chk("rlast", s_cram_rlast, e.last);
                    beat++;
                end else begin
                    stalled = 1;
                    sd = s_cram_rdata; sr = s_cram_rresp; sl = s_cram_rlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("beat_count", beat, int'(len) + 1);
        if (rmode == 0) chk("throughput", cyc, int'(len) + 1);
        s_cram_rready = 1'b0;
        chk("rvalid_end", s_cram_rvalid, 0);
        chk("arready_end", s_cram_arready, 1);
    endtask

    initial begin
        int  t, n, lens[7];
        logic [1:0] bt;
        lens = '{0, 1, 2, 3, 7, 15, 5};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_arready", s_cram_arready, 0);
        chk("rst_rvalid", s_cram_rvalid, 0);
        chk("rst_rdata", s_cram_rdata, 0);
        chk("rst_rresp", s_cram_rresp, 0);
        chk("rst_rlast", s_cram_rlast, 0);
        chk("rst_rid", s_cram_rid, 0);
        nrst = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", s_cram_arready, 1);

        for (int k = 0; k < DEPTH; k++) ld(k, 32'(k * 3));

        // Directed cases
        do_burst(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 0);        // 12,15,18,21
        do_burst(4'd2, 32'h18, 8'd3, 3'd2, 2'b10, 0);        // words 6,7,4,5
        do_burst(4'd9, 32'h0, 8'd7, 3'd2, 2'b01, 1);         // backpressure
        do_burst(4'd1, 32'h20, 8'd1, 3'd1, 2'b01, 0);        // bad size
        do_burst(4'd3, 32'h3FFC, 8'd1, 3'd2, 2'b01, 0);      // runs past the RAM
        do_burst(4'd4, 32'h8, 8'd2, 3'd2, 2'b10, 0);         // illegal WRAP length
        do_burst(4'd6, 32'h44, 8'd4, 3'd2, 2'b00, 2);        // FIXED
        do_burst(4'd7, 32'h30, 8'd1, 3'd2, 2'b11, 0);        // reserved burst

        // Reset during beat 2 of a len=7 burst
        s_cram_arid = 4'd3; s_cram_araddr = 32'h40; s_cram_arlen = 8'd7;
        s_cram_arsize = 3'd2; s_cram_arburst = 2'b01; s_cram_arvalid = 1'b1;
        t = 0;
        while (!s_cram_arready && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        s_cram_arvalid = 1'b0;
        s_cram_rready  = 1'b1;
        n = 0; t = 0;
        while (n < 2 && t < 20) begin
            if (s_cram_rvalid) n++;
            @(negedge clk); t++;
        end
        chk("pre_rst_beats", n, 2);
        nrst = 1'b0;
        #1;
        chk("midrst_rvalid", s_cram_rvalid, 0);
        chk("midrst_arready", s_cram_arready, 0);
        chk("midrst_rlast", s_cram_rlast, 0);
        @(negedge clk);
        nrst = 1'b1;
        s_cram_rready = 1'b0;
        do_burst(4'd8, 32'h40, 8'd7, 3'd2, 2'b01, 0);

`ifdef CRAM_AR_SKID_EN
        begin
            int c_last1, c_first2, c_ar2, nb;
            c_last1 = -1; c_first2 = -1; c_ar2 = -1; nb = 0;
            exp_q.delete();
            build_exp(32'h100, 8'd3, 3'd2, 2'b01);
            build_exp(32'h200, 8'd2, 3'd2, 2'b01);
            s_cram_rready = 1'b1;
            fork
                begin
                    s_cram_arid = 4'd1; s_cram_araddr = 32'h100; s_cram_arlen = 8'd3;
                    s_cram_arburst = 2'b01; s_cram_arsize = 3'd2; s_cram_arvalid = 1'b1;
                    t = 0;
                    while (!s_cram_arready && t < 20) begin @(negedge clk); t++; end
                    @(negedge clk);
                    s_cram_araddr = 32'h200; s_cram_arid = 4'd2; s_cram_arlen = 8'd2;
                    t = 0;
                    while (!s_cram_arready && t < 20) begin @(negedge clk); t++; end
                    @(negedge clk);
                    c_ar2 = cyc_cnt;
                    s_cram_arvalid = 1'b0;
                end
                begin
                    beat_t e;
                    t = 0;
                    while (nb < 7 && t < 100) begin
                        @(negedge clk); t++;
                        if (s_cram_rvalid) begin
                            e = exp_q.pop_front();
                            chk("skid_rdata", s_cram_rdata, e.data);
                            chk("skid_rlast", s_cram_rlast, e.last);
                            chk("skid_rid", s_cram_rid, (nb < 4) ? 4'd1 : 4'd2);
                            if (nb == 3) c_last1 = cyc_cnt;
                            if (nb == 4) c_first2 = cyc_cnt;
                            nb++;
                        end
                    end
                end
            join
            chk("skid_beats", nb, 7);
            chk("skid_no_gap", c_first2 - c_last1, 1);
            chk("skid_ar2_early", (c_ar2 >= 0) && (c_ar2 < c_last1), 1);
            s_cram_rready = 1'b0;
            @(negedge clk);
        end
`endif

        // Randomized bursts with interleaved loader writes
        for (int i = 0; i < 40; i++) begin
            repeat (2) ld($urandom_range(0, DEPTH - 1), $urandom);
            n  = $urandom_range(0, 9);
            bt = (n < 3) ? 2'b00 : (n < 6) ? 2'b01 : (n < 9) ? 2'b10 : 2'b11;
            do_burst(4'($urandom_range(0, 15)), 32'($urandom_range(0, 18000)),
                     8'(lens[$urandom_range(0, 6)]),
                     ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2, bt, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
